// File: rtl/seg7_display_driver.sv
// Eight-digit multiplexed seven-segment driver.
// Converts a 20-bit binary value to six BCD digits with a serial double-dabble,
// shows a mode letter on the top digit, and blinks an edit cursor with a decimal point.
module seg7_display_driver #(
  parameter int SCAN_DIV  = 12500,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] display_value,
  input  logic [3:0]  display_mode,
  input  logic [2:0]  cursor_in,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [19:0] MAX_SHOWN = 20'd999999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [SCAN_W-1:0]  scan_cnt_reg;
  logic [2:0]         scan_idx_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_on_reg;

  logic [19:0] last_value_reg;
  logic        force_reg;
  logic [19:0] bin_reg;
  logic [23:0] bcd_work_reg;
  logic [23:0] bcd_adj;
  logic [4:0]  bit_cnt_reg;
  logic [23:0] digits_reg;
  logic        ovf_reg;

  logic [3:0] digit_arr [0:5];
  logic [2:0] msd_idx;
  logic [3:0] cur_digit;
  logic       cursor_active;
  logic       is_cursor;
  logic [6:0] seg_next;
  logic       dp_next;

  logic [7:0] an_n_reg;
  logic [6:0] seg_n_reg;
  logic       dp_n_reg;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] mode_seg(input logic [3:0] m);
    logic [6:0] s;
    case (m)
      4'd0:    s = 7'b0001110;  // F
      4'd1:    s = 7'b0001100;  // P
      4'd2:    s = 7'b0100001;  // d
      4'd3:    s = 7'b0101111;  // r
      4'd4:    s = 7'b0010010;  // S
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Per-digit double-dabble correction and unpacking of the latched digits.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit
      assign bcd_adj[4*gi +: 4] = (bcd_work_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_work_reg[4*gi +: 4] + 4'd3 :
                                  bcd_work_reg[4*gi +: 4];
      assign digit_arr[gi] = digits_reg[4*gi +: 4];
    end
  endgenerate

  // Scan timer: hold each digit for SCAN_DIV cycles, then step to the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= '0;
    end else if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= scan_idx_reg + 3'd1;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
    end
  end

  // Blink timer: toggle the cursor visibility every BLINK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= ~blink_on_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
    end
  end

  // Conversion FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Conversion FSM next state: restart on a new value or after reset.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (force_reg || (display_value != last_value_reg)) state_next = SHIFT;
      SHIFT:   if (bit_cnt_reg == 5'd19) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath: sample, shift one bit per cycle, then publish all digits at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_value_reg <= '0;
      force_reg      <= 1'b1;
      bin_reg        <= '0;
      bcd_work_reg   <= '0;
      bit_cnt_reg    <= '0;
      digits_reg     <= '0;
      ovf_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (state_next == SHIFT) begin
            last_value_reg <= display_value;
            bin_reg        <= display_value;
            bcd_work_reg   <= '0;
            bit_cnt_reg    <= '0;
            force_reg      <= 1'b0;
          end
        end
        SHIFT: begin
          bcd_work_reg <= {bcd_adj[22:0], bin_reg[19]};
          bin_reg      <= {bin_reg[18:0], 1'b0};
          bit_cnt_reg  <= bit_cnt_reg + 5'd1;
        end
        DONE: begin
          digits_reg <= bcd_work_reg;
          ovf_reg    <= (last_value_reg > MAX_SHOWN);
        end
        default: ;
      endcase
    end
  end

  // Highest nonzero digit position; everything above it is blanked.
  always_comb begin
    msd_idx = 3'd0;
    for (int i = 1; i < 6; i++) begin
      if (digit_arr[i] != 4'd0) msd_idx = 3'(i);
    end
  end

  // Select the pattern for the digit currently being scanned.
  always_comb begin
    cur_digit = 4'd0;
    case (scan_idx_reg)
      3'd0:    cur_digit = digit_arr[0];
      3'd1:    cur_digit = digit_arr[1];
      3'd2:    cur_digit = digit_arr[2];
      3'd3:    cur_digit = digit_arr[3];
      3'd4:    cur_digit = digit_arr[4];
      3'd5:    cur_digit = digit_arr[5];
      default: cur_digit = 4'd0;
    endcase

    cursor_active = (display_mode == 4'd0) && (cursor_in <= 3'd2);
    is_cursor     = cursor_active && (scan_idx_reg == cursor_in);

    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (scan_idx_reg == 3'd7) begin
      seg_next = mode_seg(display_mode);
    end else if (scan_idx_reg == 3'd6) begin
      seg_next = SEG_BLANK;
    end else if (ovf_reg) begin
      seg_next = SEG_DASH;
    end else if ((scan_idx_reg <= msd_idx) || is_cursor) begin
      seg_next = digit_seg(cur_digit);
    end

    if (is_cursor) dp_next = 1'b0;
    // The cursor digit goes fully dark during the off half of the blink.
    if (is_cursor && !blink_on_reg) begin
      seg_next = SEG_BLANK;
      dp_next  = 1'b1;
    end
  end

  // Register the pad outputs so anode and segments change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n_reg  <= 8'hFF;
      seg_n_reg <= 7'h7F;
      dp_n_reg  <= 1'b1;
    end else begin
      an_n_reg  <= ~(8'b1 << scan_idx_reg);
      seg_n_reg <= seg_next;
      dp_n_reg  <= dp_next;
    end
  end

  assign an_n  = an_n_reg;
  assign seg_n = seg_n_reg;
  assign dp_n  = dp_n_reg;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Scoreboard bench: stimulus queues expected digit frames, a monitor pops them and
// compares whenever the matching anode is active. Instance dut_b scans faster so
// that cursor blinking and short-lived display states are observable.
module tb_seg7_display_driver;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010, P9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111, DS = 7'b0111111;
  localparam logic [6:0] LF = 7'b0001110, LP = 7'b0001100, LD = 7'b0100001;
  localparam logic [6:0] LR = 7'b0101111, LS = 7'b0010010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] display_value = 20'd123;
  logic [3:0]  display_mode = 4'd0;
  logic [2:0]  cursor_in = 3'd3;
  logic [7:0]  an_n, an_n_b;
  logic [6:0]  seg_n, seg_n_b;
  logic        dp_n, dp_n_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    bit         which;   // 0 = dut, 1 = dut_b
    logic [2:0] idx;
    logic [6:0] seg;
    logic       dp;
    bit         blink;   // seg/dp are the visible-phase values of a blinking cursor
    int         tag;
  } exp_t;

  exp_t sb_q[$];
  bit   mon_busy = 1'b0;

  seg7_display_driver #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk(clk), .rst(rst), .display_value(display_value), .display_mode(display_mode),
    .cursor_in(cursor_in), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
  );

  seg7_display_driver #(.SCAN_DIV(2), .BLINK_DIV(16)) dut_b (
    .clk(clk), .rst(rst), .display_value(display_value), .display_mode(display_mode),
    .cursor_in(cursor_in), .an_n(an_n_b), .seg_n(seg_n_b), .dp_n(dp_n_b)
  );

  always #5 clk = ~clk;

  // Edges since reset release, used to predict the blink phase.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit which, input int idx, input logic [6:0] seg,
                      input logic dp, input bit blink, input int tag);
    exp_t e;
    e.which = which;
    e.idx   = 3'(idx);
    e.seg   = seg;
    e.dp    = dp;
    e.blink = blink;
    e.tag   = tag;
    sb_q.push_back(e);
  endtask

  task automatic push_frame(input int tag, input logic [6:0] s7, input logic [6:0] s6,
                            input logic [6:0] s5, input logic [6:0] s4, input logic [6:0] s3,
                            input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
    push(0, 0, s0, 1'b1, 0, tag);
    push(0, 1, s1, 1'b1, 0, tag);
    push(0, 2, s2, 1'b1, 0, tag);
    push(0, 3, s3, 1'b1, 0, tag);
    push(0, 4, s4, 1'b1, 0, tag);
    push(0, 5, s5, 1'b1, 0, tag);
    push(0, 6, s6, 1'b1, 0, tag);
    push(0, 7, s7, 1'b1, 0, tag);
  endtask

  task automatic drain(input int tag);
    int n = 0;
    while ((sb_q.size() != 0 || mon_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL t%0d_drain_timeout: got %0d pending expected 0", tag, sb_q.size());
    end
  endtask

  task automatic check_reset(input int tag);
    check($sformatf("t%0d_rst_an", tag), an_n, 8'hFF);
    check($sformatf("t%0d_rst_seg", tag), seg_n, 7'h7F);
    check($sformatf("t%0d_rst_dp", tag), dp_n, 1'b1);
    check($sformatf("t%0d_rst_an_b", tag), an_n_b, 8'hFF);
    check($sformatf("t%0d_rst_seg_b", tag), seg_n_b, 7'h7F);
    check($sformatf("t%0d_rst_dp_b", tag), dp_n_b, 1'b1);
  endtask

  // Monitor: pop one expectation, wait for its digit to be enabled, compare.
  initial begin
    exp_t cur;
    int   waited = 0;
    logic [7:0] an_s, an_want;
    logic [6:0] seg_s, exp_seg;
    logic       dp_s, exp_dp;
    forever begin
      @(negedge clk);
      if (!mon_busy && sb_q.size() != 0) begin
        cur      = sb_q.pop_front();
        mon_busy = 1'b1;
        waited   = 0;
      end
      if (mon_busy) begin
        an_s    = cur.which ? an_n_b : an_n;
        seg_s   = cur.which ? seg_n_b : seg_n;
        dp_s    = cur.which ? dp_n_b : dp_n;
        an_want = ~(8'b1 << cur.idx);
        if (an_s == an_want) begin
          exp_seg = cur.seg;
          exp_dp  = cur.dp;
          if (cur.blink && ((((cyc - 1) / 16) % 2) != 0)) begin
            exp_seg = BL;
            exp_dp  = 1'b1;
          end
          check($sformatf("t%0d_%s_d%0d_seg", cur.tag, cur.which ? "b" : "a", cur.idx),
                seg_s, exp_seg);
          check($sformatf("t%0d_%s_d%0d_dp", cur.tag, cur.which ? "b" : "a", cur.idx),
                dp_s, exp_dp);
          $display("t%0d %s digit %0d seg=%b dp=%b", cur.tag, cur.which ? "b" : "a",
                   cur.idx, seg_s, dp_s);
          mon_busy = 1'b0;
        end else begin
          waited++;
          if (waited > 200) begin
            checks++;
            failures++;
            $display("FAIL t%0d_anode_timeout: got an_n %h expected %h", cur.tag, an_s, an_want);
            mon_busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] an_want;
    int  n;
    bit  ok, saw1, saw2, late1, bad;
    int  di;

    // Reset with 123 applied, then the forced first conversion.
    repeat (3) @(negedge clk);
    #1 check_reset(1);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    push_frame(1, LF, BL, BL, BL, BL, P1, P2, P3);
    drain(1);

    // Value 100, mode F, scan order and wrap.
    display_value = 20'd100;
    repeat (30) @(negedge clk);
    push_frame(2, LF, BL, BL, BL, BL, P1, P0, P0);
    push(0, 0, P0, 1'b1, 0, 2);
    drain(2);
    n = 0;
    while (an_n != 8'h7F && n < 100) begin @(negedge clk); n++; end
    while (an_n != 8'hFE && n < 100) begin @(negedge clk); n++; end
    check("t2_scan_sync", (n < 100), 1'b1);
    for (int k = 0; k < 9; k++) begin
      ok = 1'b1;
      an_want = ~(8'b1 << (k % 8));
      for (int j = 0; j < 4; j++) begin
        if (an_n != an_want) ok = 1'b0;
        @(negedge clk);
      end
      check($sformatf("t2_scan_slot%0d", k), ok, 1'b1);
    end

    // Overflow shows dashes; the largest in-range value shows all nines.
    display_value = 20'd1048575;
    repeat (30) @(negedge clk);
    push_frame(3, LF, BL, DS, DS, DS, DS, DS, DS);
    drain(3);
    display_value = 20'd999999;
    repeat (30) @(negedge clk);
    push_frame(4, LF, BL, P9, P9, P9, P9, P9, P9);
    drain(4);

    // Mode letters.
    display_mode = 4'd1; push(0, 7, LP, 1'b1, 0, 5); drain(5);
    display_mode = 4'd2; push(0, 7, LD, 1'b1, 0, 5); drain(5);
    display_mode = 4'd3; push(0, 7, LR, 1'b1, 0, 5); drain(5);
    display_mode = 4'd4; push(0, 7, LS, 1'b1, 0, 5); drain(5);
    display_mode = 4'd9; push(0, 7, DS, 1'b1, 0, 5); drain(5);

    // Cursor on a leading-zero digit, blinking; then a mode without cursor.
    display_mode  = 4'd0;
    cursor_in     = 3'd2;
    display_value = 20'd5;
    repeat (30) @(negedge clk);
    push(1, 0, P5, 1'b1, 0, 6);
    push(1, 1, BL, 1'b1, 0, 6);
    push(1, 2, P0, 1'b0, 1, 6);
    push(1, 0, P5, 1'b1, 0, 6);
    push(1, 2, P0, 1'b0, 1, 6);
    push(1, 0, P5, 1'b1, 0, 6);
    push(1, 2, P0, 1'b0, 1, 6);
    push(0, 2, P0, 1'b0, 1, 6);
    drain(6);
    display_mode = 4'd2;
    repeat (2) @(negedge clk);
    push(0, 0, P5, 1'b1, 0, 7);
    push(0, 2, BL, 1'b1, 0, 7);
    push(0, 7, LD, 1'b1, 0, 7);
    push(1, 2, BL, 1'b1, 0, 7);
    drain(7);

    // Value change during SHIFT: 111 then 222, with no intermediate pattern.
    display_mode = 4'd0;
    cursor_in    = 3'd3;
    repeat (4) @(negedge clk);
    display_value = 20'd111;
    saw1 = 0; saw2 = 0; late1 = 0; bad = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (c == 4) display_value = 20'd222;
      di = -1;
      for (int i = 0; i < 8; i++) begin
        an_want = ~(8'b1 << i);
        if (an_n_b == an_want) di = i;
      end
      if (di == 0) begin
        if (seg_n_b != P5 && seg_n_b != P1 && seg_n_b != P2) bad = 1;
        if (seg_n_b == P1) begin saw1 = 1; if (saw2) late1 = 1; end
        if (seg_n_b == P2) saw2 = 1;
      end else if (di == 1 || di == 2) begin
        if (seg_n_b != BL && seg_n_b != P1 && seg_n_b != P2) bad = 1;
      end else if (di >= 3 && di <= 5) begin
        if (seg_n_b != BL) bad = 1;
      end
    end
    check("t8_no_intermediate", bad, 1'b0);
    check("t8_saw_111", saw1, 1'b1);
    check("t8_saw_222", saw2, 1'b1);
    check("t8_order", late1, 1'b0);
    push_frame(8, LF, BL, BL, BL, BL, P2, P2, P2);
    drain(8);

    // Reset in the middle of a conversion, then a fresh conversion after release.
    display_value = 20'd456;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1 check_reset(9);
    repeat (3) @(negedge clk);
    check_reset(9);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    push_frame(9, LF, BL, BL, BL, BL, P4, P5, P6);
    drain(9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
